// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order dual-issue control with per-register busy countdowns and perf counters
module issue_scoreboard #(
  parameter int LAT_W = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i1_valid,
  input  logic [4:0]       i1_rs1,
  input  logic [4:0]       i1_rs2,
  input  logic [4:0]       i1_rd,
  input  logic             i1_use_rs1,
  input  logic             i1_use_rs2,
  input  logic             i1_regw,
  input  logic             i1_mem,
  input  logic [LAT_W-1:0] i1_lat,
  input  logic             i2_valid,
  input  logic [4:0]       i2_rs1,
  input  logic [4:0]       i2_rs2,
  input  logic [4:0]       i2_rd,
  input  logic             i2_use_rs1,
  input  logic             i2_use_rs2,
  input  logic             i2_regw,
  input  logic             i2_mem,
  input  logic [LAT_W-1:0] i2_lat,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             i1_fire,
  output logic             i2_fire,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] dual_cnt
);
  logic [LAT_W-1:0] cnt_q [1:31];
  logic [LAT_W-1:0] cnt_d [1:31];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, dual_cnt_q, dual_cnt_d;
  logic i1_ok, i2_ok, raw;
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) busy_vec[r] = cnt_q[r] != '0;
  end
  // busy_vec[0] is constant 0, so x0 sources are always ready
  assign i1_ok = (!i1_use_rs1 | !busy_vec[i1_rs1]) & (!i1_use_rs2 | !busy_vec[i1_rs2]);
  assign i2_ok = (!i2_use_rs1 | !busy_vec[i2_rs1]) & (!i2_use_rs2 | !busy_vec[i2_rs2]);
  assign raw = i1_regw & (i1_rd != 5'd0) &
               ((i2_use_rs1 & (i2_rs1 == i1_rd)) | (i2_use_rs2 & (i2_rs2 == i1_rd)));
  assign i1_fire = i1_valid & ex_ready & !flush & i1_ok;
  assign i2_fire = i1_fire & i2_valid & i2_ok & !raw & !(i1_mem & i2_mem);
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = busy_vec[r] ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
      if (i1_fire & i1_regw & (i1_rd == 5'(r))) cnt_d[r] = i1_lat;
      if (i2_fire & i2_regw & (i2_rd == 5'(r))) cnt_d[r] = i2_lat;
    end
    stall_cnt_d = (i1_valid & !i1_fire & !flush & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    dual_cnt_d  = (i2_fire & ~&dual_cnt_q) ? dual_cnt_q + CNT_W'(1) : dual_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
      dual_cnt_q  <= '0;
    end else begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
      dual_cnt_q  <= dual_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign dual_cnt  = dual_cnt_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: scenario tasks with an expected-fire queue checked each cycle
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic i1_valid, i1_use_rs1, i1_use_rs2, i1_regw, i1_mem;
  logic i2_valid, i2_use_rs1, i2_use_rs2, i2_regw, i2_mem;
  logic [4:0] i1_rs1, i1_rs2, i1_rd, i2_rs1, i2_rs2, i2_rd;
  logic [1:0] i1_lat, i2_lat;
  logic ex_ready, flush;
  logic i1_fire, i2_fire, i1_fire_s, i2_fire_s;
  logic [31:0] busy_vec, busy_vec_s;
  logic [31:0] stall_cnt, dual_cnt;
  logic [2:0] stall_cnt_s, dual_cnt_s;
  int vec = 0;
  int errs = 0;
  logic [1:0] fq[$];
  logic [1:0] e;

  issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .i1_valid(i1_valid), .i1_rs1(i1_rs1), .i1_rs2(i1_rs2), .i1_rd(i1_rd),
    .i1_use_rs1(i1_use_rs1), .i1_use_rs2(i1_use_rs2), .i1_regw(i1_regw), .i1_mem(i1_mem), .i1_lat(i1_lat),
    .i2_valid(i2_valid), .i2_rs1(i2_rs1), .i2_rs2(i2_rs2), .i2_rd(i2_rd),
    .i2_use_rs1(i2_use_rs1), .i2_use_rs2(i2_use_rs2), .i2_regw(i2_regw), .i2_mem(i2_mem), .i2_lat(i2_lat),
    .ex_ready(ex_ready), .flush(flush),
    .i1_fire(i1_fire), .i2_fire(i2_fire), .busy_vec(busy_vec), .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
  );

  issue_scoreboard #(.LAT_W(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .i1_valid(i1_valid), .i1_rs1(i1_rs1), .i1_rs2(i1_rs2), .i1_rd(i1_rd),
    .i1_use_rs1(i1_use_rs1), .i1_use_rs2(i1_use_rs2), .i1_regw(i1_regw), .i1_mem(i1_mem), .i1_lat(i1_lat),
    .i2_valid(i2_valid), .i2_rs1(i2_rs1), .i2_rs2(i2_rs2), .i2_rd(i2_rd),
    .i2_use_rs1(i2_use_rs1), .i2_use_rs2(i2_use_rs2), .i2_regw(i2_regw), .i2_mem(i2_mem), .i2_lat(i2_lat),
    .ex_ready(ex_ready), .flush(flush),
    .i1_fire(i1_fire_s), .i2_fire(i2_fire_s), .busy_vec(busy_vec_s), .stall_cnt(stall_cnt_s), .dual_cnt(dual_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic s1(input logic v, input logic [4:0] a, b, d, input logic ua, ub, w, m, input logic [1:0] l);
    i1_valid = v; i1_rs1 = a; i1_rs2 = b; i1_rd = d;
    i1_use_rs1 = ua; i1_use_rs2 = ub; i1_regw = w; i1_mem = m; i1_lat = l;
  endtask

  task automatic s2(input logic v, input logic [4:0] a, b, d, input logic ua, ub, w, m, input logic [1:0] l);
    i2_valid = v; i2_rs1 = a; i2_rs2 = b; i2_rd = d;
    i2_use_rs1 = ua; i2_use_rs2 = ub; i2_regw = w; i2_mem = m; i2_lat = l;
  endtask

  task automatic idle();
    s1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    s2(0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    fq.push_back(2'b00);
    @(negedge clk);
    e = fq.pop_front(); vec++;
    if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL reset fire got %b want %b", {i1_fire, i2_fire}, e); end
    vec++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL reset busy got %h want 0", busy_vec); end
    vec++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL reset stall got %0d want 0", stall_cnt); end
    vec++; if (dual_cnt !== 32'd0) begin errs++; $display("FAIL reset dual got %0d want 0", dual_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_independent();
    s1(1, 2, 3, 1, 1, 1, 1, 0, 0);
    s2(1, 5, 6, 4, 1, 1, 1, 0, 0);
    fq.push_back(2'b11);
    @(negedge clk);
    e = fq.pop_front(); vec++;
    if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL indep fire got %b want %b", {i1_fire, i2_fire}, e); end
    @(posedge clk); #1;
    idle();
    vec++; if (dual_cnt !== 32'd1) begin errs++; $display("FAIL indep dual got %0d want 1", dual_cnt); end
    vec++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL indep busy got %h want 0", busy_vec); end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        s1(1, 1, 2, 5, 1, 1, 1, 0, 0);
        s2(1, 5, 0, 7, 1, 0, 1, 0, 0);
      end else begin
        s1(1, 5, 0, 7, 1, 0, 1, 0, 0);
        s2(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      fq.push_back(2'b10);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL raw c%0d fire got %b want %b", c, {i1_fire, i2_fire}, e); end
      @(posedge clk); #1;
      vec++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL raw c%0d busy got %h want 0", c, busy_vec); end
    end
    idle();
    vec++; if (dual_cnt !== 32'd1) begin errs++; $display("FAIL raw dual got %0d want 1", dual_cnt); end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) s1(1, 1, 0, 6, 1, 0, 1, 1, 2);
      else s1(1, 6, 0, 8, 1, 0, 1, 0, 0);
      s2(0, 0, 0, 0, 0, 0, 0, 0, 0);
      fq.push_back((c == 0 || c == 3) ? 2'b10 : 2'b00);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL load_use c%0d fire got %b want %b", c, {i1_fire, i2_fire}, e); end
      @(posedge clk); #1;
      vec++; if (busy_vec[6] !== (c < 2)) begin errs++; $display("FAIL load_use c%0d busy6 got %b want %b", c, busy_vec[6], c < 2); end
    end
    idle();
    vec++; if (stall_cnt !== 32'd2) begin errs++; $display("FAIL load_use stall got %0d want 2", stall_cnt); end
  endtask

  task automatic test_mem_pair();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        s1(1, 1, 0, 9, 1, 0, 1, 1, 0);
        s2(1, 2, 3, 0, 1, 1, 0, 1, 0);
      end else if (c == 1) begin
        s1(1, 2, 3, 0, 1, 1, 0, 1, 0);
        s2(1, 1, 2, 0, 1, 1, 1, 0, 3);
      end else begin
        s1(1, 1, 2, 0, 1, 1, 1, 0, 3);
        s2(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      fq.push_back(c == 1 ? 2'b11 : 2'b10);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL mem_pair c%0d fire got %b want %b", c, {i1_fire, i2_fire}, e); end
      @(posedge clk); #1;
      vec++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL mem_pair c%0d busy got %h want 0", c, busy_vec); end
    end
    idle();
    vec++; if (dual_cnt !== 32'd2) begin errs++; $display("FAIL mem_pair dual got %0d want 2", dual_cnt); end
  endtask

  task automatic test_waw();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        s1(1, 1, 2, 11, 1, 1, 1, 0, 0);
        s2(1, 3, 4, 11, 1, 1, 1, 0, 2);
      end else idle();
      fq.push_back(c == 0 ? 2'b11 : 2'b00);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL waw c%0d fire got %b want %b", c, {i1_fire, i2_fire}, e); end
      @(posedge clk); #1;
      vec++; if (busy_vec[11] !== (c < 2)) begin errs++; $display("FAIL waw c%0d busy11 got %b want %b", c, busy_vec[11], c < 2); end
    end
    vec++; if (dual_cnt !== 32'd3) begin errs++; $display("FAIL waw dual got %0d want 3", dual_cnt); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) s1(1, 1, 0, 10, 1, 0, 1, 0, 3);
      if (c == 1 || c == 2) begin
        s1(1, 1, 2, 12, 1, 1, 1, 0, 0);
        s2(1, 3, 4, 13, 1, 1, 1, 0, 0);
        flush = (c == 1);
        ex_ready = (c != 2);
      end
      fq.push_back(c == 0 ? 2'b10 : 2'b00);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL flush c%0d fire got %b want %b", c, {i1_fire, i2_fire}, e); end
      @(posedge clk); #1;
      vec++; if (busy_vec[10] !== (c < 3)) begin errs++; $display("FAIL flush c%0d busy10 got %b want %b", c, busy_vec[10], c < 3); end
      vec++; if (stall_cnt !== (c >= 2 ? 32'd3 : 32'd2)) begin errs++; $display("FAIL flush c%0d stall got %0d want %0d", c, stall_cnt, c >= 2 ? 3 : 2); end
    end
    vec++; if (dual_cnt !== 32'd3) begin errs++; $display("FAIL flush dual got %0d want 3", dual_cnt); end
  endtask

  task automatic test_reset_mid();
    idle();
    s1(1, 1, 0, 7, 1, 0, 1, 0, 3);
    fq.push_back(2'b10);
    @(negedge clk);
    e = fq.pop_front(); vec++;
    if ({i1_fire, i2_fire} !== e) begin errs++; $display("FAIL reset_mid fire got %b want %b", {i1_fire, i2_fire}, e); end
    @(posedge clk); #1;
    vec++; if (busy_vec[7] !== 1'b1) begin errs++; $display("FAIL reset_mid busy7 got %b want 1", busy_vec[7]); end
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    vec++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL reset_mid busy got %h want 0", busy_vec); end
    vec++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL reset_mid stall got %0d want 0", stall_cnt); end
    vec++; if (dual_cnt !== 32'd0) begin errs++; $display("FAIL reset_mid dual got %0d want 0", dual_cnt); end
    vec++; if (stall_cnt_s !== 3'd0 || dual_cnt_s !== 3'd0) begin errs++; $display("FAIL reset_mid small got %0d/%0d want 0/0", stall_cnt_s, dual_cnt_s); end
  endtask

  task automatic test_saturate();
    idle();
    s1(1, 1, 2, 14, 1, 1, 1, 0, 0);
    ex_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      fq.push_back(2'b00);
      @(negedge clk);
      e = fq.pop_front(); vec++;
      if ({i1_fire, i2_fire} !== e || {i1_fire_s, i2_fire_s} !== e) begin
        errs++; $display("FAIL sat c%0d fire got %b/%b want %b", c, {i1_fire, i2_fire}, {i1_fire_s, i2_fire_s}, e);
      end
      @(posedge clk); #1;
    end
    idle();
    vec++; if (stall_cnt !== 32'd10) begin errs++; $display("FAIL sat stall got %0d want 10", stall_cnt); end
    vec++; if (stall_cnt_s !== 3'd7) begin errs++; $display("FAIL sat small_stall got %0d want 7", stall_cnt_s); end
    vec++; if (busy_vec_s !== 32'h0) begin errs++; $display("FAIL sat small_busy got %h want 0", busy_vec_s); end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_load_use();
    test_mem_pair();
    test_waw();
    test_flush();
    test_reset_mid();
    test_saturate();
    if (fq.size() != 0) begin errs++; $display("FAIL queue leftover %0d want 0", fq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller in front of the dual-issue launch stage of the in-order RISC-V core.
- Takes the two oldest decoded instructions and tracks pending register writes with per-register countdown counters.
- Decides each cycle whether to issue none, slot 1 only, or both, under in-order, hazard and structural rules.
- Keeps saturating stall and dual-issue performance counters.

Parameters:
- LAT_W, 2, width of the per-instruction result-latency field and of each per-register busy counter.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i1_valid  in  1  slot 1 (older) instruction present
- i1_rs1, i1_rs2, i1_rd  in  5 each  register indices
- i1_use_rs1, i1_use_rs2  in  1 each  source operand actually read
- i1_regw  in  1  instruction writes rd
- i1_mem  in  1  instruction uses the memory port
- i1_lat  in  LAT_W  extra cycles before rd is forwardable (0 = next cycle)
- i2_valid, i2_rs1, i2_rs2, i2_rd, i2_use_rs1, i2_use_rs2, i2_regw, i2_mem, i2_lat  in  same as slot 1  slot 2 (younger) instruction
- ex_ready  in  1  execute stage can accept this cycle
- flush  in  1  redirect; suppress issue this cycle
- i1_fire  out  1  slot 1 issued (queue pops it)
- i2_fire  out  1  slot 2 issued
- busy_vec  out  32  bit r = register r has a pending write
- stall_cnt  out  CNT_W  cycles slot 1 was valid but not issued
- dual_cnt  out  CNT_W  cycles with dual issue

Behaviour:
- State:
  - cnt[1..31], each LAT_W bits. cnt[0] does not exist and x0 is never busy.
  - stall_cnt and dual_cnt.
- Reset (rst==0 at a clk edge): all cnt = 0, stall_cnt = 0, dual_cnt = 0.
  - Fire outputs are combinational from state and inputs, so they are 0 whenever valid inputs are 0.
  - Reset mid-operation discards all pending busy state.
- Operand ready: src_ok = !use | (rs==0) | (cnt[rs]==0).
- i1_fire = i1_valid & ex_ready & !flush & src_ok(rs1) & src_ok(rs2). All same-cycle combinational.
- i2_fire = i1_fire & i2_valid & src_ok(i2 rs1) & src_ok(i2 rs2) & !raw & !(i1_mem & i2_mem).
  - raw = i1_regw & (i1_rd!=0) & ((i2_use_rs1 & i2_rs1==i1_rd) | (i2_use_rs2 & i2_rs2==i1_rd)).
  - WAW inside a pair is permitted.
  - i2_valid with !i1_valid never fires (strict in-order).
- Counter update at each clk edge (rst==1):
  - Each nonzero cnt[r] decrements by 1.
  - If i1_fire & i1_regw & i1_rd!=0: cnt[i1_rd] <= i1_lat.
  - If i2_fire & i2_regw & i2_rd!=0: cnt[i2_rd] <= i2_lat. Slot 2 wins when rds match.
  - A set overrides the decrement for that register.
- Timing: writer issued at cycle T with lat L; a dependent can issue no earlier than T+1+L. L=0 gives back-to-back issue via bypass.
- flush or !ex_ready:
  - No issue that cycle.
  - Counters keep decrementing; writers already in flight still complete, and killed writers only expire conservatively.
- busy_vec[r] = (cnt[r]!=0); busy_vec[0] = 0. Registered-state derived, no input path.
- stall_cnt: +1 when i1_valid & !i1_fire & !flush; saturates at all-ones.
- dual_cnt: +1 when i2_fire; saturates at all-ones.

Test Plan:
- Independent pair (x1<-x2,x3; x4<-x5,x6), ex_ready=1 -> i1_fire=i2_fire=1 same cycle; dual_cnt 0->1.
- Intra-pair RAW: i1 writes x5 lat 0, i2 reads x5 -> cycle 0 i1_fire=1, i2_fire=0; next cycle, with that instruction in slot 1, it fires; busy_vec stays 0.
- Load x6 lat 2 issued at T; dependent in slot 1 from T+1 -> busy_vec[6]=1 at T+1 and T+2; i1_fire=0 at T+1 and T+2; fires at T+3; stall_cnt +2.
- Two memory ops, all operands ready -> only i1_fire=1; i2 issues next cycle. i1_rd=0 with regw=1, lat 3 -> busy_vec stays 0.
- Valid pair with flush=1, then ex_ready=0 -> no fire either cycle; stall_cnt +1 only for the ex_ready cycle; existing cnt values still decrement.
- cnt[7]=3, assert rst=0 for one edge -> busy_vec=0, stall_cnt=dual_cnt=0 next cycle; preload stall_cnt=all-ones and stall -> stays all-ones.
